// File: rtl/decode_stage.sv
// Decode / operand-fetch stage: IF/ID hold register, scoreboard hazard stall, ID/EX output register.
// Optional macro DECODE_BYPASS_EN forwards a same-cycle writeback into a stalled source operand.
module decode_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [31:0] in_instr,
  output logic        in_ready,
  output logic [4:0]  Ain1,
  output logic [4:0]  Ain2,
  input  logic [31:0] DOut1,
  input  logic [31:0] DOut2,
  input  logic        wb_valid,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_dest,
  output logic        out_we,
  output logic [31:0] out_op1,
  output logic [31:0] out_op2,
  output logic [31:0] out_imm,
  output logic        out_illegal,
  output logic [15:0] stall_count
);

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LOAD  = 6'b100011;
  localparam logic [5:0] OP_STORE = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] v);
    logic signed [15:0]       s;
    logic signed [DATA_W-1:0] w;
    s = signed'(v);
    w = DATA_W'(s);
    return unsigned'(w);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic              held_valid;
  logic [31:0]       held_instr;
  logic [31:0]       busy, busy_nxt;
  logic [DATA_W-1:0] rd1_n, rd2_n;

  logic [5:0]        opc;
  logic [4:0]        rs, rt, rd;
  logic              use_rs, use_rt, illegal, we;
  logic [4:0]        dest_raw, dest;
  logic              src1_busy, src2_busy, byp1, byp2, hazard, advance;
  logic [DATA_W-1:0] op1_sel, op2_sel;

  assign opc  = held_instr[31:26];
  assign rs   = held_instr[25:21];
  assign rt   = held_instr[20:16];
  assign rd   = held_instr[15:11];
  assign Ain1 = rs;
  assign Ain2 = rt;

  always_comb begin
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    dest_raw = 5'd0;
    illegal  = 1'b0;
    case (opc)
      OP_RTYPE: begin use_rs = 1'b1; use_rt = 1'b1; dest_raw = rd; end
      OP_LOAD:  begin use_rs = 1'b1; dest_raw = rt; end
      OP_STORE: begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_BEQ:   begin use_rs = 1'b1; use_rt = 1'b1; end
      OP_ADDI:  begin use_rs = 1'b1; dest_raw = rt; end
      default:  illegal = 1'b1;
    endcase
  end

  // r0 is never a real destination, so it never enters the scoreboard
  assign we        = (dest_raw != 5'd0);
  assign dest      = we ? dest_raw : 5'd0;
  assign src1_busy = use_rs & busy[rs];
  assign src2_busy = use_rt & busy[rt];

`ifdef DECODE_BYPASS_EN
  assign byp1 = src1_busy & wb_valid & (wb_addr == rs);
  assign byp2 = src2_busy & wb_valid & (wb_addr == rt);
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data;
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  assign op1_sel  = byp1 ? wb_data : rd1_n;
  assign op2_sel  = byp2 ? wb_data : rd2_n;
  assign hazard   = (src1_busy & ~byp1) | (src2_busy & ~byp2) | (we & busy[dest]);
  assign advance  = held_valid & ~hazard & (~out_valid | out_ready);
  assign in_ready = ~held_valid | advance;

  // Set after clear so an issuing writer wins over a retiring one on the same register
  always_comb begin
    busy_nxt = busy;
    if (wb_valid) busy_nxt[wb_addr] = 1'b0;
    if (advance && we) busy_nxt[dest] = 1'b1;
  end

  // Register-file read stage: operands for held_instr captured mid-cycle
  always_ff @(negedge clk) begin
    rd1_n <= DOut1;
    rd2_n <= DOut2;
  end

  // IF/ID stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_valid  <= 1'b0;
      held_instr  <= 32'd0;
      busy        <= 32'd0;
      stall_count <= 16'd0;
    end else begin
      if (in_valid && in_ready) begin
        held_valid <= 1'b1;
        held_instr <= in_instr;
      end else if (advance) begin
        held_valid <= 1'b0;
      end
      busy <= busy_nxt;
      if (held_valid && hazard) stall_count <= sat_inc16(stall_count);
    end
  end

  // ID/EX stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_opcode  <= 6'd0;
      out_dest    <= 5'd0;
      out_we      <= 1'b0;
      out_op1     <= '0;
      out_op2     <= '0;
      out_imm     <= '0;
      out_illegal <= 1'b0;
    end else if (advance) begin
      out_valid   <= 1'b1;
      out_opcode  <= opc;
      out_dest    <= dest;
      out_we      <= we;
      out_op1     <= op1_sel;
      out_op2     <= op2_sel;
      out_imm     <= sign_ext16(held_instr[15:0]);
      out_illegal <= illegal;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; register file modelled here.
// Build with +define+DECODE_BYPASS_EN to check the forwarding variant.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'd0;
  logic        in_ready;
  logic [4:0]  Ain1, Ain2;
  logic [31:0] DOut1, DOut2;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = 5'd0;
  logic [31:0] wb_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_opcode;
  logic [4:0]  out_dest;
  logic        out_we;
  logic [31:0] out_op1, out_op2, out_imm;
  logic        out_illegal;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] rf [32];

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .Ain1(Ain1), .Ain2(Ain2), .DOut1(DOut1), .DOut2(DOut2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_dest(out_dest),
    .out_we(out_we), .out_op1(out_op1), .out_op2(out_op2), .out_imm(out_imm),
    .out_illegal(out_illegal), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Register file: fixed contents after reset, written by writeback at posedge
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      rf[1] <= 32'd5;
      rf[2] <= 32'd7;
      rf[5] <= 32'd55;
    end else if (wb_valid && wb_addr != 5'd0) begin
      rf[wb_addr] <= wb_data;
    end
  end
  assign DOut1 = rf[Ain1];
  assign DOut2 = rf[Ain2];

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    in_valid = 1'b0; wb_valid = 1'b0; out_ready = 1'b1;
    reset = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL reset_stall_count got %0d want 0", stall_count); end
    checks++; if ({Ain1, Ain2} !== 10'd0) begin errors++; $display("FAIL reset_ain got %0d/%0d want 0/0", Ain1, Ain2); end
    checks++; if ({out_dest, out_we, out_op1, out_op2, out_imm, out_illegal, out_opcode} !== '0) begin
      errors++; $display("FAIL reset_out_fields got dest=%0d op1=%0h imm=%0h want all 0", out_dest, out_op1, out_imm); end
    reset = 1'b0;
  endtask

  task automatic test_add;
    do_reset();
    in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_not_early got %b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b want 1", out_valid); end
    checks++; if (out_op1 !== 32'd5) begin errors++; $display("FAIL add_op1 got %0d want 5", out_op1); end
    checks++; if (out_op2 !== 32'd7) begin errors++; $display("FAIL add_op2 got %0d want 7", out_op2); end
    checks++; if (out_dest !== 5'd3 || out_we !== 1'b1) begin
      errors++; $display("FAIL add_dest got %0d/%b want 3/1", out_dest, out_we); end
    checks++; if (out_imm !== 32'h0000_1820 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL add_imm got %h/%b want 00001820/0", out_imm, out_illegal); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", out_valid); end
  endtask

  task automatic test_raw;
    do_reset();
    in_valid = 1'b1; in_instr = rtype(5'd1, 5'd2, 5'd3);
    tick();
    in_instr = rtype(5'd3, 5'd1, 5'd4);
    tick();
    in_valid = 1'b0;
    checks++; if (out_dest !== 5'd3 || out_op1 !== 32'd5) begin
      errors++; $display("FAIL raw_first got dest=%0d op1=%0d want 3/5", out_dest, out_op1); end
    tick();
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL raw_stall1 got %0d want 1", stall_count); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL raw_stalled got valid=%b ready=%b want 0/0", out_valid, in_ready); end
    wb_valid = 1'b1; wb_addr = 5'd3; wb_data = 32'd12;
    tick();
    wb_valid = 1'b0;
`ifdef DECODE_BYPASS_EN
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd4) begin
      errors++; $display("FAIL raw_bypass_issue got valid=%b dest=%0d want 1/4", out_valid, out_dest); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL raw_bypass_count got %0d want 1", stall_count); end
`else
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_wb_cycle got %b want 0", out_valid); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL raw_stall2 got %0d want 2", stall_count); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd4) begin
      errors++; $display("FAIL raw_issue got valid=%b dest=%0d want 1/4", out_valid, out_dest); end
`endif
    checks++; if (out_op1 !== 32'd12) begin errors++; $display("FAIL raw_op1 got %0d want 12", out_op1); end
    checks++; if (out_op2 !== 32'd5) begin errors++; $display("FAIL raw_op2 got %0d want 5", out_op2); end
  endtask

  task automatic test_backpressure;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = itype(6'b001000, 5'd1, 5'd5, 16'd3);
    tick();
    in_instr = itype(6'b001000, 5'd2, 5'd6, 16'd4);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_dest !== 5'd5 || out_op1 !== 32'd5 || out_imm !== 32'd3) begin
        errors++; $display("FAIL bp_hold%0d got v=%b dest=%0d op1=%0d imm=%0d want 1/5/5/3", i, out_valid, out_dest, out_op1, out_imm); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); end
    end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL bp_no_stall got %0d want 0", stall_count); end
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd6 || out_op1 !== 32'd7 || out_imm !== 32'd4) begin
      errors++; $display("FAIL bp_second got v=%b dest=%0d op1=%0d imm=%0d want 1/6/7/4", out_valid, out_dest, out_op1, out_imm); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_imm_illegal;
    do_reset();
    in_valid = 1'b1; in_instr = itype(6'b001000, 5'd1, 5'd0, 16'hFFFF);
    tick();
    in_instr = rtype(5'd0, 5'd0, 5'd7);
    tick();
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL r0_imm got %h want ffffffff", out_imm); end
    checks++; if (out_we !== 1'b0 || out_dest !== 5'd0 || out_illegal !== 1'b0) begin
      errors++; $display("FAIL r0_nowrite got we=%b dest=%0d ill=%b want 0/0/0", out_we, out_dest, out_illegal); end
    in_instr = {6'b111111, 5'd7, 5'd7, 5'd7, 11'd0};
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_dest !== 5'd7 || out_op1 !== 32'd0) begin
      errors++; $display("FAIL r0_read got v=%b dest=%0d op1=%0d want 1/7/0", out_valid, out_dest, out_op1); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_opcode !== 6'h3F) begin
      errors++; $display("FAIL illegal got v=%b ill=%b opc=%h want 1/1/3f", out_valid, out_illegal, out_opcode); end
    checks++; if (out_we !== 1'b0 || out_dest !== 5'd0) begin
      errors++; $display("FAIL illegal_nowrite got we=%b dest=%0d want 0/0", out_we, out_dest); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL illegal_no_stall got %0d want 0", stall_count); end
  endtask

  task automatic test_reset_mid;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = itype(6'b001000, 5'd1, 5'd5, 16'd1);
    tick();
    in_instr = itype(6'b001000, 5'd1, 5'd6, 16'd2);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got v=%b ready=%b want 1/0", out_valid, in_ready); end
    #2 reset = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_dest !== 5'd0 || Ain2 !== 5'd0) begin
      errors++; $display("FAIL mid_async got v=%b ready=%b dest=%0d ain2=%0d want 0/1/0/0", out_valid, in_ready, out_dest, Ain2); end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = rtype(5'd5, 5'd5, 5'd8);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_op1 !== 32'd55 || out_dest !== 5'd8) begin
      errors++; $display("FAIL mid_reissue got v=%b op1=%0d dest=%0d want 1/55/8", out_valid, out_op1, out_dest); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL mid_no_stall got %0d want 0", stall_count); end
  endtask

  task automatic test_saturate;
    do_reset();
    in_valid = 1'b1; in_instr = itype(6'b001000, 5'd1, 5'd9, 16'd0);
    tick();
    in_instr = rtype(5'd9, 5'd9, 5'd10);
    tick();
    in_valid = 1'b0;
    repeat (65534) tick();
    checks++; if (stall_count !== 16'hFFFE) begin errors++; $display("FAIL sat_near got %h want fffe", stall_count); end
    repeat (6) tick();
    checks++; if (stall_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h want ffff", stall_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_still_stalled got %b want 0", out_valid); end
  endtask

  initial begin
    #1_200_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_add();
    test_raw();
    test_backpressure();
    test_imm_illegal();
    test_reset_mid();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode / operand-fetch stage of the RISC pipeline. Accepts 32-bit instructions from fetch over a valid/ready handshake. Drives the register-file read addresses and captures the returned operands into an ID/EX output register. Tracks in-flight destination registers in a scoreboard and stalls on RAW/WAW hazards until writeback clears them.

## Interface
- No parameters; widths fixed: 32-bit datapath, 5-bit register address, 32 registers.
- clk  in  1  single clock; posedge sequential logic; register-file read occurs at negedge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_instr  in  32  instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- Ain1  out  5  register-file read address 1 (rs).
- Ain2  out  5  register-file read address 2 (rt).
- DOut1  in  32  register-file read data 1.
- DOut2  in  32  register-file read data 2.
- wb_valid  in  1  writeback retiring a result this cycle.
- wb_addr  in  5  writeback destination.
- wb_data  in  32  writeback data; used only with bypass.
- out_valid  out  1  ID/EX register holds a decoded instruction.
- out_ready  in  1  execute consumes the output this cycle.
- out_opcode  out  6  instr[31:26].
- out_dest  out  5  destination register; 0 if none.
- out_we  out  1  instruction writes a register.
- out_op1  out  32  rs operand.
- out_op2  out  32  rt operand.
- out_imm  out  32  sign-extended instr[15:0].
- out_illegal  out  1  unrecognised opcode.
- stall_count  out  16  saturating count of hazard-stall cycles.

## Operation
- Decode (opcode = instr[31:26]; rs = [25:21]; rt = [20:16]; rd = [15:11]):
  - 000000 R-type: reads rs, rt; writes rd.
  - 100011 load: reads rs; writes rt.
  - 101011 store: reads rs, rt; no write.
  - 000100 beq: reads rs, rt; no write.
  - 001000 addi: reads rs; writes rt.
  - Any other opcode: out_illegal=1; no write; no source checks.
- Destination 0 gives out_we=0 and out_dest=0, and is never marked busy.
- Held register: one-entry IF/ID register (held_valid, held_instr). Ain1/Ain2 are driven combinationally from held_instr.
- Scoreboard: 32-bit busy vector.
  - Hazard when any used source register is busy, or when the destination is busy (WAW).
- Flow signals:
  - advance = held_valid & ~hazard & (~out_valid | out_ready).
  - in_ready = ~held_valid | advance.
- On advance:
  - ID/EX register loads decode fields and the operands sampled at the preceding negedge.
  - busy[dest] is set when out_we=1.
- On wb_valid: busy[wb_addr] is cleared.
  - Simultaneous set and clear of the same register: set wins.
- If out_valid & out_ready and no advance, out_valid falls to 0.
- stall_count increments each cycle in which held_valid & hazard. It saturates at 0xFFFF.

## Timing
- Reset, asynchronous: held_valid=0, out_valid=0, busy=0, stall_count=0. All out_* data fields are 0, and Ain1=Ain2=0.
- Reset mid-operation discards the held and output instructions. The scoreboard clears with no writeback required.
- Latency: an instruction accepted at posedge N appears with out_valid=1 after posedge N+1 if hazard-free. Each stall cycle adds one.
- Throughput: one instruction per cycle; accept and advance may occur on the same edge.
- Backpressure: when out_ready=0 with out_valid=1, all out_* fields are held stable and in_ready follows ~held_valid.
- Without bypass, a RAW stall on register r ends the cycle after the posedge where wb_valid & wb_addr=r. The following negedge read returns the written value.

## Configuration
- DECODE_BYPASS_EN defined: a busy source that equals wb_addr with wb_valid=1 in the same cycle is not a hazard. Its operand is taken from wb_data instead of DOut. This saves one stall cycle. WAW checks are unchanged.
- DECODE_BYPASS_EN undefined: no forwarding; behaviour is as in Timing.

## Test plan
- Reset then issue R-type add r3,r1,r2 with r1=5, r2=7 in the register file -> out_valid after one cycle; op1=5, op2=7, out_dest=3, out_we=1; busy[3]=1.
- add r3,r1,r2 then sub r4,r3,r1 back-to-back, wb of r3 data 12 two cycles later -> sub stalls; stall_count increments each stall cycle; sub issues with op1=12. With DECODE_BYPASS_EN, sub issues in the wb cycle using wb_data.
- out_ready=0 for 3 cycles with two instructions queued -> out_* fields stable, in_ready=0 once held; both instructions emerge in order after release.
- addi r0,r1,-1 -> out_imm=0xFFFFFFFF, out_we=0, busy unchanged. Opcode 111111 -> out_illegal=1.
- Assert reset while held_valid=1, out_valid=1 and busy[5]=1 -> all cleared immediately; an instruction reading r5 then issues without a stall.
- Force more than 65535 stall cycles -> stall_count holds at 0xFFFF.
